// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one UART transmitter among NUM_REQ byte-stream requesters.
//   Round-robin arbitration at message granularity: once a requester wins
//   with a non-last byte it owns the transmitter until its `last` byte.
//   A one-entry registered output stage feeds tx_data/tx_valid.
//
//   Optional feature: define UART_TX_ARB_LOCK_TIMEOUT_EN to release a lock
//   whose owner has been idle for LOCK_TIMEOUT cycles. Without the macro a
//   lock is held until the owner's `last` byte.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 2,
    parameter int LOCK_TIMEOUT = 100000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ*8-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [7:0]           tx_data,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 busy
);

    localparam int IDX_W = $clog2(NUM_REQ);

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] owner;
    logic [IDX_W-1:0] win_idx;
    logic [IDX_W-1:0] sel;
    logic             win_found;
    logic             sel_en;
    logic             sel_last;
    logic [7:0]       sel_data;
    logic             space;
    logic             xfer;

`ifdef UART_TX_ARB_LOCK_TIMEOUT_EN
    localparam int CNT_W = $clog2(LOCK_TIMEOUT + 1);
    logic [CNT_W-1:0] idle_cnt;
`endif

    if (NUM_REQ < 2 || NUM_REQ > 8 || LOCK_TIMEOUT < 1) begin : g_param_check
        $error("uart_tx_arbiter: NUM_REQ must be 2..8 and LOCK_TIMEOUT >= 1");
    end

    // Circular priority scan starting just after the previous message owner.
    always_comb begin
        // NOTE: every variable assigned in a combinational block gets a
        // default first, otherwise paths that skip it infer a latch.
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!win_found && req_valid[(int'(ptr) + k) % NUM_REQ]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'((int'(ptr) + k) % NUM_REQ);
            end
        end
    end

    // Select the one requester allowed to hand over a byte this cycle.
    always_comb begin
        space     = !tx_valid || tx_ready;
        sel       = (state == LOCKED) ? owner : win_idx;
        sel_en    = (state == LOCKED) || win_found;
        sel_data  = req_data[8*int'(sel) +: 8];
        sel_last  = req_last[sel];
        xfer      = !rst && sel_en && space && req_valid[sel];
        req_ready = '0;
        if (!rst && sel_en && space) begin
            req_ready[sel] = 1'b1;
        end
    end

    assign busy = (state == LOCKED) || tx_valid;

    // Output register, lock state machine and round-robin pointer.
    always_ff @(posedge clk) begin
        // NOTE: sequential state is updated with non-blocking assignments so
        // every register samples the pre-edge values of the others.
        if (rst) begin
            state    <= IDLE;
            ptr      <= IDX_W'(NUM_REQ - 1);
            owner    <= '0;
            grant    <= '0;
            tx_valid <= 1'b0;
            tx_data  <= 8'h00;
`ifdef UART_TX_ARB_LOCK_TIMEOUT_EN
            idle_cnt <= '0;
`endif
        end else begin
            // Drain first; a load in the same cycle overrides and keeps valid high.
            if (tx_valid && tx_ready) begin
                tx_valid <= 1'b0;
            end
            if (xfer) begin
                tx_valid <= 1'b1;
                tx_data  <= sel_data;
            end

            case (state)
                IDLE: begin
                    if (xfer) begin
                        ptr <= sel;
                        if (!sel_last) begin
                            state <= LOCKED;
                            owner <= sel;
                            grant <= NUM_REQ'(1) << sel;
`ifdef UART_TX_ARB_LOCK_TIMEOUT_EN
                            idle_cnt <= '0;
`endif
                        end
                    end
                end
                LOCKED: begin
                    if (xfer) begin
`ifdef UART_TX_ARB_LOCK_TIMEOUT_EN
                        idle_cnt <= '0;
`endif
                        if (sel_last) begin
                            state <= IDLE;
                            grant <= '0;
                            ptr   <= owner;
                        end
                    end
`ifdef UART_TX_ARB_LOCK_TIMEOUT_EN
                    else if (!req_valid[owner]) begin
                        // The count reaches LOCK_TIMEOUT on this edge; the
                        // following cycle is already IDLE.
                        idle_cnt <= idle_cnt + 1'b1;
                        if (idle_cnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
                            state <= IDLE;
                            grant <= '0;
                            ptr   <= owner;
                        end
                    end
`endif
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter
//   Scoreboard bench for uart_tx_arbiter (NUM_REQ=2, LOCK_TIMEOUT=16).
//   Requester queues hold the bytes to present; the expected transmit order
//   is pushed to exp_q when each scenario is set up and popped on every
//   tx_valid && tx_ready handshake.
module tb_uart_tx_arbiter;

    localparam int NUM_REQ      = 2;
    localparam int LOCK_TIMEOUT = 16;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } beat_t;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [NUM_REQ*8-1:0] req_data = '0;
    logic [NUM_REQ-1:0]   req_valid = '0;
    logic [NUM_REQ-1:0]   req_last = '0;
    logic [NUM_REQ-1:0]   req_ready;
    logic [7:0]           tx_data;
    logic                 tx_valid;
    logic                 tx_ready = 1'b1;
    logic [NUM_REQ-1:0]   grant;
    logic                 busy;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NUM_REQ      (NUM_REQ),
        .LOCK_TIMEOUT (LOCK_TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_data  (req_data),
        .req_valid (req_valid),
        .req_last  (req_last),
        .req_ready (req_ready),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .grant     (grant),
        .busy      (busy)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    beat_t              q0[$];
    beat_t              q1[$];
    logic [7:0]         exp_q[$];
    logic [NUM_REQ-1:0] exp_grant = '0;
    logic [NUM_REQ-1:0] xfer_seen = '0;
    logic [NUM_REQ-1:0] rdy_seen  = '0;
    logic               chk_grant = 1'b0;
    logic               load_pend = 1'b0;
    logic [7:0]         load_byte = 8'h00;
    logic               tx_rdy_drv = 1'b1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, limit 500000", $time);
        $fatal(1, "watchdog");
    end

    // One clock cycle: check last load, present queue heads, observe handshakes.
    task automatic tick();
        logic [7:0] want;
        beat_t      b;
        @(negedge clk);
        cyc++;
        if (load_pend) begin
            total++;
            if (tx_valid !== 1'b1 || tx_data !== load_byte) begin
                bad++;
                $display("FAIL load_latency: tx_valid=%b tx_data=%h, want 1/%h", tx_valid, tx_data, load_byte);
            end
            load_pend = 1'b0;
        end
        if (chk_grant) begin
            total++;
            if (grant !== exp_grant) begin
                bad++;
                $display("FAIL grant: got %b want %b (cycle %0d)", grant, exp_grant, cyc);
            end
        end
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        if (q0.size() > 0) begin
            req_valid[0]   = 1'b1;
            req_data[7:0]  = q0[0].data;
            req_last[0]    = q0[0].last;
        end
        if (q1.size() > 0) begin
            req_valid[1]   = 1'b1;
            req_data[15:8] = q1[0].data;
            req_last[1]    = q1[0].last;
        end
        tx_ready = tx_rdy_drv;
        #1;
        rdy_seen  = req_ready;
        xfer_seen = req_valid & req_ready;
        if (tx_valid && tx_ready) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL tx_unexpected: got %h want none", tx_data);
            end else begin
                want = exp_q.pop_front();
                if (tx_data !== want) begin
                    bad++;
                    $display("FAIL tx_order: got %h want %h", tx_data, want);
                end
            end
        end
        total++;
        if (!$onehot0(req_ready)) begin
            bad++;
            $display("FAIL ready_onehot: got %b want at most one bit", req_ready);
        end
        if (xfer_seen[0]) begin
            b = q0.pop_front();
            load_pend = 1'b1;
            load_byte = b.data;
            exp_grant = b.last ? 2'b00 : 2'b01;
        end
        if (xfer_seen[1]) begin
            b = q1.pop_front();
            load_pend = 1'b1;
            load_byte = b.data;
            exp_grant = b.last ? 2'b00 : 2'b10;
        end
    endtask

    task automatic run_drain(input int budget, input string name);
        int n = 0;
        while ((q0.size() > 0 || q1.size() > 0 || exp_q.size() > 0 || load_pend) && n < budget) begin
            tick();
            n++;
        end
        total++;
        if (q0.size() > 0 || q1.size() > 0 || exp_q.size() > 0 || load_pend) begin
            bad++;
            $display("FAIL %s_drain: got %0d bytes outstanding after %0d cycles, want 0",
                     name, exp_q.size(), budget);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        tx_ready  = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        q0.delete();
        q1.delete();
        exp_q.delete();
        exp_grant = '0;
        load_pend = 1'b0;
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        req_valid  = 2'b11;
        req_last   = 2'b11;
        req_data   = 16'h3A3A;
        tx_rdy_drv = 1'b1;
        repeat (3) begin
            @(negedge clk);
            total++;
            if (req_ready !== 2'b00) begin
                bad++;
                $display("FAIL reset_ready: got %b want 00", req_ready);
            end
        end
        total++;
        if (tx_valid !== 1'b0 || tx_data !== 8'h00 || grant !== 2'b00 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: got valid=%b data=%h grant=%b busy=%b want 0/00/00/0",
                     tx_valid, tx_data, grant, busy);
        end
        rst       = 1'b0;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        repeat (20) begin
            tick();
            total++;
            if ({tx_valid, busy, rdy_seen, grant} !== 6'b0) begin
                bad++;
                $display("FAIL idle: got valid=%b busy=%b ready=%b grant=%b want all 0",
                         tx_valid, busy, rdy_seen, grant);
            end
        end
    endtask

    task automatic test_single_message();
        logic [7:0] msg [7] = '{8'h0D, 8'h0A, 8'h31, 8'h35, 8'h31, 8'h3E, 8'h20};
        do_reset();
        chk_grant = 1'b1;
        for (int i = 0; i < 7; i++) begin
            q0.push_back('{data: msg[i], last: (i == 6)});
            exp_q.push_back(msg[i]);
        end
        run_drain(40, "single_message");
        chk_grant = 1'b0;
    endtask

    task automatic test_round_robin();
        logic [7:0] a [3] = '{8'h61, 8'h62, 8'h63};
        logic [7:0] b [3] = '{8'h41, 8'h42, 8'h43};
        int c0;
        do_reset();
        chk_grant = 1'b1;
        for (int m = 0; m < 2; m++)
            for (int i = 0; i < 3; i++) q0.push_back('{data: a[i], last: (i == 2)});
        for (int i = 0; i < 3; i++) q1.push_back('{data: b[i], last: (i == 2)});
        for (int i = 0; i < 3; i++) exp_q.push_back(a[i]);
        for (int i = 0; i < 3; i++) exp_q.push_back(b[i]);
        for (int i = 0; i < 3; i++) exp_q.push_back(a[i]);
        c0 = cyc;
        run_drain(60, "round_robin");
        // Nine bytes at one per cycle plus the final drain cycle.
        total++;
        if (cyc - c0 != 10) begin
            bad++;
            $display("FAIL rr_throughput: got %0d cycles want 10", cyc - c0);
        end
        chk_grant = 1'b0;
    endtask

    task automatic test_backpressure();
        do_reset();
        tx_rdy_drv = 1'b0;
        q0.push_back('{data: 8'h55, last: 1'b1});
        q0.push_back('{data: 8'h56, last: 1'b1});
        exp_q.push_back(8'h55);
        exp_q.push_back(8'h56);
        tick();
        total++;
        if (xfer_seen !== 2'b01) begin
            bad++;
            $display("FAIL bp_first_accept: got %b want 01", xfer_seen);
        end
        repeat (50) begin
            tick();
            total++;
            if (tx_valid !== 1'b1 || tx_data !== 8'h55 || rdy_seen !== 2'b00 || busy !== 1'b1) begin
                bad++;
                $display("FAIL bp_hold: got valid=%b data=%h ready=%b busy=%b want 1/55/00/1",
                         tx_valid, tx_data, rdy_seen, busy);
            end
        end
        tx_rdy_drv = 1'b1;
        run_drain(10, "backpressure");
        repeat (5) tick();
        total++;
        if (tx_valid !== 1'b0) begin
            bad++;
            $display("FAIL bp_no_dup: got tx_valid=%b data=%h want 0", tx_valid, tx_data);
        end
    endtask

    task automatic test_mid_reset();
        int n = 0;
        do_reset();
        tx_rdy_drv = 1'b1;
        q0.push_back('{data: 8'h6D, last: 1'b0});
        q0.push_back('{data: 8'h6E, last: 1'b0});
        q0.push_back('{data: 8'h6F, last: 1'b1});
        exp_q.push_back(8'h6D);
        exp_q.push_back(8'h6E);
        do begin
            tick();
            n++;
        end while (!(xfer_seen[0] && load_byte == 8'h6E) && n < 10);
        @(negedge clk);
        total++;
        if (tx_valid !== 1'b1 || tx_data !== 8'h6E || grant !== 2'b01) begin
            bad++;
            $display("FAIL mid_precond: got valid=%b data=%h grant=%b want 1/6e/01", tx_valid, tx_data, grant);
        end
        rst      = 1'b1;
        tx_ready = 1'b0;
        #1;
        total++;
        if (req_ready !== 2'b00) begin
            bad++;
            $display("FAIL mid_reset_ready: got %b want 00", req_ready);
        end
        @(negedge clk);
        total++;
        if (tx_valid !== 1'b0 || grant !== 2'b00 || busy !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset_state: got valid=%b grant=%b busy=%b want 0/00/0", tx_valid, grant, busy);
        end
        rst       = 1'b0;
        req_valid = '0;
        q0.delete();
        q1.delete();
        exp_q.delete();
        exp_grant = '0;
        load_pend = 1'b0;
        q1.push_back('{data: 8'h3A, last: 1'b1});
        exp_q.push_back(8'h3A);
        tick();
        total++;
        if (xfer_seen !== 2'b10) begin
            bad++;
            $display("FAIL mid_reset_grant: got %b want 10", xfer_seen);
        end
        run_drain(10, "mid_reset");
    endtask

    task automatic test_lock_timeout();
        int t74 = -1;
        int t3b = -1;
        do_reset();
        tx_rdy_drv = 1'b1;
        q0.push_back('{data: 8'h74, last: 1'b0});
        q1.push_back('{data: 8'h3B, last: 1'b1});
        exp_q.push_back(8'h74);
`ifdef UART_TX_ARB_LOCK_TIMEOUT_EN
        exp_q.push_back(8'h3B);
        for (int n = 0; n < 60 && t3b < 0; n++) begin
            tick();
            if (xfer_seen[0] && load_byte == 8'h74) t74 = cyc;
            if (xfer_seen[1]) t3b = cyc;
            if (t74 >= 0 && cyc > t74 && cyc <= t74 + LOCK_TIMEOUT) begin
                total++;
                if (grant !== 2'b01) begin
                    bad++;
                    $display("FAIL timeout_lock_held: got %b want 01 (cycle %0d)", grant, cyc);
                end
            end
        end
        // Sixteen idle locked cycles, then req1 is accepted on the next one.
        total++;
        if (t74 < 0 || t3b - t74 != LOCK_TIMEOUT + 1) begin
            bad++;
            $display("FAIL timeout_release: got %0d cycles want %0d", t3b - t74, LOCK_TIMEOUT + 1);
        end
        run_drain(10, "timeout");
`else
        for (int n = 0; n < 60; n++) begin
            tick();
            if (n > 0) begin
                total++;
                if (xfer_seen[1] !== 1'b0 || grant !== 2'b01) begin
                    bad++;
                    $display("FAIL lock_held: got xfer=%b grant=%b want x0/01 (cycle %0d)", xfer_seen, grant, cyc);
                end
            end
        end
        q0.push_back('{data: 8'h2E, last: 1'b1});
        exp_q.push_back(8'h2E);
        exp_q.push_back(8'h3B);
        run_drain(20, "lock_hold");
`endif
    endtask

    initial begin
        test_reset();
        test_single_message();
        test_round_robin();
        test_backpressure();
        test_mid_reset();
        test_lock_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
